// File: rtl/matrix_stream_loader.sv
// Streams operand elements into two flat matrix buses, fires a one-cycle start
// pulse at the multiplier and holds the operands until it signals completion.

module matrix_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module matrix_stream_loader #(
  parameter int FIRST_MATRIX_HEIGHT = 2,
  parameter int BOTH_MATRIX_W_H     = 2,
  parameter int SECOND_MATRIX_WIDTH = 2,
  parameter int DATA_WIDTH          = 8,
  localparam int N1 = FIRST_MATRIX_HEIGHT*BOTH_MATRIX_W_H,
  localparam int N2 = SECOND_MATRIX_WIDTH*BOTH_MATRIX_W_H
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_abort,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic                     i_valid,
  output logic                     o_in_ready,
  output logic [N1*DATA_WIDTH-1:0] o_matrix_1,
  output logic [N2*DATA_WIDTH-1:0] o_matrix_2,
  output logic                     o_calc,
  input  logic                     i_mult_ready,
  output logic                     o_busy,
  output logic                     o_done
);
  localparam int NMAX = (N1 > N2) ? N1 : N2;
  localparam int CW   = $clog2(NMAX) + 1;

  typedef enum logic [1:0] {LOAD1, LOAD2, CALC, WAIT} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 rdy_q;
  logic                 xfer;
  logic [N1-1:0]        we1;
  logic [N2-1:0]        we2;
  logic [N1-1:0][DATA_WIDTH-1:0] m1;
  logic [N2-1:0][DATA_WIDTH-1:0] m2;

  // Abort beats a same-cycle transfer, so the element is simply dropped.
  assign xfer = i_valid && o_in_ready && !i_abort;

  // First element received lands in the most significant slot.
  for (genvar k = 0; k < N1; k++) begin : g_m1
    assign we1[k] = xfer && (state == LOAD1) && (cnt == CW'(k));
    matrix_slot #(.DW(DATA_WIDTH)) u_slot (
      .clk(clk), .rst(i_rst), .we(we1[k]), .d(i_data), .q(m1[N1-1-k])
    );
  end

  for (genvar k = 0; k < N2; k++) begin : g_m2
    assign we2[k] = xfer && (state == LOAD2) && (cnt == CW'(k));
    matrix_slot #(.DW(DATA_WIDTH)) u_slot (
      .clk(clk), .rst(i_rst), .we(we2[k]), .d(i_data), .q(m2[N2-1-k])
    );
  end

  assign o_matrix_1 = m1;
  assign o_matrix_2 = m2;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= LOAD1;
      cnt        <= '0;
      rdy_q      <= 1'b0;
      o_calc     <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_in_ready <= 1'b1;
    end else begin
      rdy_q  <= i_mult_ready;
      o_calc <= 1'b0;
      o_done <= 1'b0;
      if (i_abort) begin
        state      <= LOAD1;
        cnt        <= '0;
        o_busy     <= 1'b0;
        o_in_ready <= 1'b1;
      end else begin
        case (state)
          LOAD1: if (xfer) begin
            if (cnt == CW'(N1-1)) begin
              cnt   <= '0;
              state <= LOAD2;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          LOAD2: if (xfer) begin
            if (cnt == CW'(N2-1)) begin
              cnt        <= '0;
              state      <= CALC;
              o_calc     <= 1'b1;
              o_busy     <= 1'b1;
              o_in_ready <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          CALC: state <= WAIT;
          // Only a fresh rise counts; a level left over from the last job is ignored.
          WAIT: if (i_mult_ready && !rdy_q) begin
            o_done     <= 1'b1;
            o_busy     <= 1'b0;
            o_in_ready <= 1'b1;
            state      <= LOAD1;
          end
          default: state <= LOAD1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench: expectations queued with the stimulus, a negedge monitor
// checks each o_calc / o_done pulse against the queue head.

module tb_matrix_stream_loader;
  logic        clk = 1'b0;
  logic        i_rst, i_abort, i_valid;
  logic [7:0]  i_data;
  logic        i_mult_ready;
  logic        o_in_ready, o_calc, o_busy, o_done;
  logic [31:0] o_matrix_1, o_matrix_2;

  bit          auto_m = 1'b1;
  logic        mr_man = 1'b0;
  logic        mr_auto = 1'b0;
  int          dly = 0;
  logic [63:0] res_model = '0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] m1;
    logic [31:0] m2;
    bit          chk_res;
    logic [63:0] res;
  } exp_t;

  exp_t calc_q[$];
  exp_t done_q[$];

  localparam logic [63:0] RES_A = {16'd19, 16'd22, 16'd43, 16'd50};
  localparam logic [63:0] RES_B = {16'd267, 16'd286, 16'd323, 16'd346};

  always #5 clk = ~clk;

  assign i_mult_ready = auto_m ? mr_auto : mr_man;

  matrix_stream_loader #(
    .FIRST_MATRIX_HEIGHT(2), .BOTH_MATRIX_W_H(2),
    .SECOND_MATRIX_WIDTH(2), .DATA_WIDTH(8)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_abort(i_abort), .i_data(i_data),
    .i_valid(i_valid), .o_in_ready(o_in_ready), .o_matrix_1(o_matrix_1),
    .o_matrix_2(o_matrix_2), .o_calc(o_calc), .i_mult_ready(i_mult_ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // 2x2 * 2x2 reference multiplier, row-major result r00,r01,r10,r11
  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] r [2][2];
    logic [7:0]  ea, eb;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        r[i][j] = '0;
        for (int k = 0; k < 2; k++) begin
          ea = a[(3-(i*2+k))*8 +: 8];
          eb = b[(3-(k*2+j))*8 +: 8];
          r[i][j] = r[i][j] + 16'(ea) * 16'(eb);
        end
      end
    return {r[0][0], r[0][1], r[1][0], r[1][1]};
  endfunction

  // Downstream multiplier model: drops ready on start, raises it 6 cycles later
  always @(posedge clk) begin
    if (o_calc) begin
      mr_auto   <= 1'b0;
      dly       <= 6;
      res_model <= prod(o_matrix_1, o_matrix_2);
    end else if (dly > 1) begin
      dly <= dly - 1;
    end else if (dly == 1) begin
      dly     <= 0;
      mr_auto <= 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (o_calc) begin
      if (calc_q.size() == 0) chk("calc_unexpected", 64'(o_calc), 64'd0);
      else begin
        e = calc_q.pop_front();
        chk("calc_m1", 64'(o_matrix_1), 64'(e.m1));
        chk("calc_m2", 64'(o_matrix_2), 64'(e.m2));
      end
    end
    if (o_done) begin
      if (done_q.size() == 0) chk("done_unexpected", 64'(o_done), 64'd0);
      else begin
        e = done_q.pop_front();
        chk("done_m1", 64'(o_matrix_1), 64'(e.m1));
        chk("done_m2", 64'(o_matrix_2), 64'(e.m2));
        if (e.chk_res) chk("done_result", res_model, e.res);
      end
    end
  end

  task automatic push(input logic [31:0] m1, input logic [31:0] m2,
                      input bit do_done, input bit chk_res, input logic [63:0] res);
    exp_t e;
    e.m1 = m1; e.m2 = m2; e.chk_res = chk_res; e.res = res;
    calc_q.push_back(e);
    if (do_done) done_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    int t = 0;
    i_valid = 1'b1;
    i_data  = d;
    while (!o_in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 50) chk("send_timeout", 64'(o_in_ready), 64'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic stream(input int first, input int cnt, input bit gap);
    for (int i = 0; i < cnt; i++) begin
      send(8'(first + i));
      if (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (o_done) begin seen = 1'b1; break; end
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(o_in_ready), 64'd1);
    chk({tag, "_m1"},       64'(o_matrix_1), 64'd0);
    chk({tag, "_m2"},       64'(o_matrix_2), 64'd0);
    chk({tag, "_calc"},     64'(o_calc),     64'd0);
    chk({tag, "_busy"},     64'(o_busy),     64'd0);
    chk({tag, "_done"},     64'(o_done),     64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b0; i_abort = 1'b0; i_valid = 1'b0; i_data = '0;
    #2 i_rst = 1'b1;
    #2 check_reset("reset");
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;

    // Basic load with backpressure during WAIT
    push(32'h01020304, 32'h05060708, 1'b1, 1'b1, RES_A);
    stream(1, 8, 1'b0);
    @(negedge clk);
    chk("calc_latency", 64'(o_calc), 64'd1);
    chk("calc_busy", 64'(o_busy), 64'd1);
    chk("calc_in_ready", 64'(o_in_ready), 64'd0);
    i_valid = 1'b1; i_data = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(o_in_ready), 64'd0);
      chk("bp_calc_pulse", 64'(o_calc), 64'd0);
      chk("bp_m1", 64'(o_matrix_1), 64'h01020304);
      chk("bp_m2", 64'(o_matrix_2), 64'h05060708);
    end
    i_valid = 1'b0;
    wait_done(30);
    @(negedge clk);
    chk("post_done_pulse", 64'(o_done), 64'd0);
    chk("post_done_ready", 64'(o_in_ready), 64'd1);
    chk("post_done_busy", 64'(o_busy), 64'd0);

    // Gapped stream after backpressure: counter must still start from 0
    push(32'h01020304, 32'h05060708, 1'b1, 1'b1, RES_A);
    stream(1, 8, 1'b1);
    wait_done(30);

    // Stale ready level entering WAIT
    auto_m = 1'b0; mr_man = 1'b1;
    push(32'h01020304, 32'h05060708, 1'b0, 1'b0, '0);
    stream(1, 8, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("stale_busy", 64'(o_busy), 64'd1);
      chk("stale_no_done", 64'(o_done), 64'd0);
    end
    mr_man = 1'b0;
    repeat (2) @(negedge clk);
    done_q.push_back('{32'h01020304, 32'h05060708, 1'b0, 64'd0});
    mr_man = 1'b1;
    @(negedge clk);
    chk("stale_done", 64'(o_done), 64'd1);
    @(negedge clk);
    chk("stale_done_pulse", 64'(o_done), 64'd0);
    chk("stale_load1", 64'(o_in_ready), 64'd1);

    // Abort after 3 elements, with a simultaneous transfer that must be dropped
    auto_m = 1'b1;
    stream(8'h21, 3, 1'b0);
    i_valid = 1'b1; i_data = 8'h24; i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(o_in_ready), 64'd1);
    chk("abort_busy", 64'(o_busy), 64'd0);
    push(32'h090A0B0C, 32'h0D0E0F10, 1'b1, 1'b1, RES_B);
    stream(9, 8, 1'b0);
    wait_done(30);

    // Abort during WAIT: no done, busy drops next cycle, operands retained
    auto_m = 1'b0; mr_man = 1'b0;
    push(32'h01020304, 32'h05060708, 1'b0, 1'b0, '0);
    stream(1, 8, 1'b0);
    repeat (2) @(negedge clk);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    @(negedge clk);
    chk("wabort_busy", 64'(o_busy), 64'd0);
    chk("wabort_in_ready", 64'(o_in_ready), 64'd1);
    chk("wabort_m1", 64'(o_matrix_1), 64'h01020304);
    chk("wabort_m2", 64'(o_matrix_2), 64'h05060708);
    mr_man = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("wabort_no_done", 64'(o_done), 64'd0);
    end
    mr_man = 1'b0;

    // Async reset mid-LOAD2, then a full reload
    auto_m = 1'b1;
    stream(1, 6, 1'b0);
    #3 i_rst = 1'b1;
    #1 check_reset("async_reset");
    #1 i_rst = 1'b0;
    push(32'h01020304, 32'h05060708, 1'b1, 1'b1, RES_A);
    stream(1, 8, 1'b0);
    @(negedge clk);
    chk("reload_calc", 64'(o_calc), 64'd1);
    wait_done(30);

    repeat (3) @(negedge clk);
    chk("calc_q_drained", 64'(calc_q.size()), 64'd0);
    chk("done_q_drained", 64'(done_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
